// File: rtl/traffic_monitor_mp.sv
// Per-port packet monitor: parses header/size/payload flits, builds one record per
// packet, arbitrates pending records round-robin into a small output FIFO.
module traffic_monitor_mp #(
  parameter int unsigned FLIT_SIZE  = 32,
  parameter int unsigned NPORT      = 5,
  parameter logic [15:0] ADDRESS    = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NPORT-1:0]                    rx_i,
  input  logic [NPORT-1:0]                    credit_i,
  input  logic [NPORT-1:0][FLIT_SIZE-1:0]     data_i,
  input  logic [63:0]                         tick_cntr_i,
  output logic                                rec_valid_o,
  input  logic                                rec_ready_i,
  output logic [2:0]                          rec_port_o,
  output logic [15:0]                         rec_addr_o,
  output logic [63:0]                         rec_time_o,
  output logic [15:0]                         rec_target_o,
  output logic [31:0]                         rec_size_o,
  output logic [31:0]                         rec_service_o,
  output logic [15:0]                         rec_task_o,
  output logic [15:0]                         rec_cons_o,
  output logic [31:0]                         rec_bw_o,
  output logic [15:0]                         drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_SIZE    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  typedef struct packed {
    logic [2:0]  port;
    logic [63:0] tstamp;
    logic [15:0] target;
    logic [31:0] size;
    logic [31:0] service;
    logic [15:0] task_id;
    logic [15:0] cons;
    logic [31:0] bw;
  } rec_t;

  logic [NPORT-1:0][1:0]  state_q;
  logic [NPORT-1:0][15:0] target_q;
  logic [NPORT-1:0][63:0] tstamp_q;
  logic [NPORT-1:0][31:0] size_q;
  logic [NPORT-1:0][31:0] rem_q;
  logic [NPORT-1:0][31:0] service_q;
  logic [NPORT-1:0][15:0] task_q;
  logic [NPORT-1:0][15:0] cons_q;
  logic [NPORT-1:0][31:0] bw_q;
  logic [NPORT-1:0][1:0]  idx_q;

  logic [NPORT-1:0]       accept;
  logic [NPORT-1:0]       complete;
  rec_t [NPORT-1:0]       new_rec;

  rec_t [NPORT-1:0]       slot_q;
  logic [NPORT-1:0]       slot_v_q;
  logic [2:0]             rr_q;
  logic                   gnt_v;
  logic [2:0]             gnt_port;
  logic [2:0]             cand;

  logic [3:0]             drop_n;
  logic [16:0]            drop_sum;
  logic [15:0]            drop_q;

  rec_t [FIFO_DEPTH-1:0]  mem_q;
  logic [AW-1:0]          wr_q;
  logic [AW-1:0]          rd_q;
  logic [AW:0]            cnt_q;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  rec_t                   head;

  assign accept = rx_i & credit_i;

  // The completing flit is merged here so the record leaves in the same cycle it arrives.
  always_comb begin
    complete = '0;
    new_rec  = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      new_rec[p].port    = 3'(p);
      new_rec[p].tstamp  = tstamp_q[p];
      new_rec[p].target  = target_q[p];
      new_rec[p].size    = size_q[p];
      new_rec[p].service = service_q[p];
      new_rec[p].task_id = task_q[p];
      new_rec[p].cons    = cons_q[p];
      new_rec[p].bw      = (bw_q[p] == '1) ? bw_q[p] : bw_q[p] + 32'd1;
      if (accept[p]) begin
        if (state_q[p] == ST_SIZE && data_i[p][31:0] == 32'd0) begin
          complete[p]     = 1'b1;
          new_rec[p].size = '0;
        end else if (state_q[p] == ST_PAYLOAD && rem_q[p] == 32'd1) begin
          complete[p] = 1'b1;
          case (idx_q[p])
            2'd0:    new_rec[p].service = data_i[p][31:0];
            2'd1:    new_rec[p].task_id = data_i[p][15:0];
            2'd2:    new_rec[p].cons    = data_i[p][15:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= '0;
      target_q  <= '0;
      tstamp_q  <= '0;
      size_q    <= '0;
      rem_q     <= '0;
      service_q <= '0;
      task_q    <= '0;
      cons_q    <= '0;
      bw_q      <= '0;
      idx_q     <= '0;
    end else begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        if (state_q[p] != ST_HEADER && bw_q[p] != '1) bw_q[p] <= bw_q[p] + 32'd1;
        if (accept[p]) begin
          case (state_q[p])
            ST_HEADER: begin
              target_q[p]  <= data_i[p][15:0];
              tstamp_q[p]  <= tick_cntr_i;
              bw_q[p]      <= 32'd1;
              service_q[p] <= '0;
              task_q[p]    <= '0;
              cons_q[p]    <= '0;
              state_q[p]   <= ST_SIZE;
            end
            ST_SIZE: begin
              size_q[p]  <= data_i[p][31:0];
              rem_q[p]   <= data_i[p][31:0];
              idx_q[p]   <= '0;
              state_q[p] <= (data_i[p][31:0] == 32'd0) ? ST_HEADER : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
              case (idx_q[p])
                2'd0:    service_q[p] <= data_i[p][31:0];
                2'd1:    task_q[p]    <= data_i[p][15:0];
                2'd2:    cons_q[p]    <= data_i[p][15:0];
                default: ;
              endcase
              if (idx_q[p] != 2'd3) idx_q[p] <= idx_q[p] + 2'd1;
              rem_q[p] <= rem_q[p] - 32'd1;
              if (rem_q[p] == 32'd1) state_q[p] <= ST_HEADER;
            end
            default: state_q[p] <= ST_HEADER;
          endcase
        end
      end
    end
  end

  assign fifo_full = (cnt_q == (AW+1)'(FIFO_DEPTH));

  always_comb begin
    gnt_v    = 1'b0;
    gnt_port = '0;
    cand     = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        cand = 3'((32'(rr_q) + i) % NPORT);
        if (!gnt_v && slot_v_q[cand]) begin
          gnt_v    = 1'b1;
          gnt_port = cand;
        end
      end
    end
  end

  always_comb begin
    drop_n = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (complete[p] && slot_v_q[p] && !(gnt_v && gnt_port == 3'(p))) drop_n = drop_n + 4'd1;
    end
    drop_sum = {1'b0, drop_q} + 17'(drop_n);
  end

  // A slot granted this cycle is free to take the port's new record on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q   <= '0;
      slot_v_q <= '0;
      rr_q     <= '0;
      drop_q   <= '0;
    end else begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        if (complete[p] && (!slot_v_q[p] || (gnt_v && gnt_port == 3'(p)))) begin
          slot_q[p]   <= new_rec[p];
          slot_v_q[p] <= 1'b1;
        end else if (gnt_v && gnt_port == 3'(p)) begin
          slot_v_q[p] <= 1'b0;
        end
      end
      if (gnt_v) rr_q <= (gnt_port == 3'(NPORT-1)) ? 3'd0 : gnt_port + 3'd1;
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign push = gnt_v;
  assign pop  = (cnt_q != '0) && rec_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= slot_q[gnt_port];
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign head          = mem_q[rd_q];
  assign rec_valid_o   = (cnt_q != '0);
  assign rec_port_o    = head.port;
  assign rec_addr_o    = ADDRESS;
  assign rec_time_o    = head.tstamp;
  assign rec_target_o  = head.target;
  assign rec_size_o    = head.size;
  assign rec_service_o = head.service;
  assign rec_task_o    = head.task_id;
  assign rec_cons_o    = head.cons;
  assign rec_bw_o      = head.bw;
  assign drop_cnt_o    = drop_q;
  assign fifo_level_o  = cnt_q;

endmodule

// File: tb/tb_traffic_monitor_mp.sv
// Directed and randomized checks of traffic_monitor_mp against a packet-level reference model.
module tb_traffic_monitor_mp;
  localparam int          NP    = 5;
  localparam int          FS    = 32;
  localparam int          DEPTH = 4;
  localparam logic [15:0] ADDR  = 16'hA5C3;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NP-1:0]          rx_i;
  logic [NP-1:0]          credit_i;
  logic [NP-1:0][FS-1:0]  data_i;
  logic [63:0]            tick_cntr_i;
  logic                   rec_valid_o;
  logic                   rec_ready_i;
  logic [2:0]             rec_port_o;
  logic [15:0]            rec_addr_o;
  logic [63:0]            rec_time_o;
  logic [15:0]            rec_target_o;
  logic [31:0]            rec_size_o;
  logic [31:0]            rec_service_o;
  logic [15:0]            rec_task_o;
  logic [15:0]            rec_cons_o;
  logic [31:0]            rec_bw_o;
  logic [15:0]            drop_cnt_o;
  logic [2:0]             fifo_level_o;

  traffic_monitor_mp #(
    .FLIT_SIZE (FS),
    .NPORT     (NP),
    .ADDRESS   (ADDR),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .credit_i     (credit_i),
    .data_i       (data_i),
    .tick_cntr_i  (tick_cntr_i),
    .rec_valid_o  (rec_valid_o),
    .rec_ready_i  (rec_ready_i),
    .rec_port_o   (rec_port_o),
    .rec_addr_o   (rec_addr_o),
    .rec_time_o   (rec_time_o),
    .rec_target_o (rec_target_o),
    .rec_size_o   (rec_size_o),
    .rec_service_o(rec_service_o),
    .rec_task_o   (rec_task_o),
    .rec_cons_o   (rec_cons_o),
    .rec_bw_o     (rec_bw_o),
    .drop_cnt_o   (drop_cnt_o),
    .fifo_level_o (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic [63:0] tm;
    logic [15:0] tg;
    logic [31:0] sz;
    logic [31:0] sv;
    logic [15:0] tk;
    logic [15:0] cn;
    logic [31:0] bw;
  } mrec_t;

  // Reference model: flit count within the packet, pending record per port, FIFO as a queue.
  int          ph   [NP];
  logic [15:0] m_tg [NP];
  logic [63:0] m_tm [NP];
  logic [31:0] m_sz [NP];
  logic [31:0] m_sv [NP];
  logic [15:0] m_tk [NP];
  logic [15:0] m_cn [NP];
  longint      m_t0 [NP];
  mrec_t       m_slot   [NP];
  bit          m_slot_v [NP];
  int          m_rr;
  int          m_drop;
  mrec_t       m_q[$];

  longint      cyc;
  logic [63:0] tick;
  int          total = 0;
  int          bad   = 0;
  logic [63:0] hdr_tick [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0; m_slot_v[p] = 0;
    end
    m_q.delete();
    m_rr   = 0;
    m_drop = 0;
  endtask

  task automatic model_edge();
    mrec_t nrec [NP];
    bit    done [NP];
    int    g;
    int    k;
    bit    pop;
    for (int p = 0; p < NP; p++) begin
      done[p] = 0;
      if (rx_i[p] && credit_i[p]) begin
        if (ph[p] == 0) begin
          m_tg[p] = data_i[p][15:0]; m_tm[p] = tick_cntr_i; m_t0[p] = cyc;
          m_sv[p] = '0; m_tk[p] = '0; m_cn[p] = '0; ph[p] = 1;
        end else if (ph[p] == 1) begin
          m_sz[p] = data_i[p][31:0];
          if (m_sz[p] == 0) begin done[p] = 1; ph[p] = 0; end
          else ph[p] = 2;
        end else begin
          k = ph[p] - 2;
          if (k == 0) m_sv[p] = data_i[p][31:0];
          if (k == 1) m_tk[p] = data_i[p][15:0];
          if (k == 2) m_cn[p] = data_i[p][15:0];
          if (longint'(k + 1) == longint'(m_sz[p])) begin done[p] = 1; ph[p] = 0; end
          else ph[p]++;
        end
      end
      if (done[p]) begin
        nrec[p].port = p;      nrec[p].tm = m_tm[p]; nrec[p].tg = m_tg[p];
        nrec[p].sz   = m_sz[p]; nrec[p].sv = m_sv[p]; nrec[p].tk = m_tk[p];
        nrec[p].cn   = m_cn[p]; nrec[p].bw = 32'(cyc - m_t0[p] + 1);
      end
    end
    g = -1;
    if (m_q.size() < DEPTH) begin
      for (int i = 0; i < NP; i++) begin
        if (g < 0 && m_slot_v[(m_rr + i) % NP]) g = (m_rr + i) % NP;
      end
    end
    pop = (m_q.size() > 0) && rec_ready_i;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(m_slot[g]);
      m_slot_v[g] = 0;
      m_rr = (g + 1) % NP;
    end
    for (int p = 0; p < NP; p++) begin
      if (done[p]) begin
        if (m_slot_v[p]) begin
          if (m_drop < 16'hFFFF) m_drop++;
        end else begin
          m_slot[p] = nrec[p]; m_slot_v[p] = 1;
        end
      end
    end
  endtask

  task automatic check_outs();
    mrec_t h;
    chk("valid", rec_valid_o, m_q.size() > 0);
    chk("level", fifo_level_o, m_q.size());
    chk("drop", drop_cnt_o, m_drop);
    if (m_q.size() > 0) begin
      h = m_q[0];
      chk("port", rec_port_o, h.port);
      chk("addr", rec_addr_o, ADDR);
      chk("time", rec_time_o, h.tm);
      chk("target", rec_target_o, h.tg);
      chk("size", rec_size_o, h.sz);
      chk("service", rec_service_o, h.sv);
      chk("task", rec_task_o, h.tk);
      chk("cons", rec_cons_o, h.cn);
      chk("bw", rec_bw_o, h.bw);
    end
  endtask

  task automatic step(input logic [NP-1:0] rx, input logic [NP-1:0] cr,
                      input logic [NP-1:0][FS-1:0] dat, input logic rdy);
    rx_i = rx; credit_i = cr; data_i = dat; rec_ready_i = rdy; tick_cntr_i = tick;
    @(posedge clk_i);
    model_edge();
    tick++;
    cyc++;
    #1;
    check_outs();
  endtask

  task automatic flit(input int p, input logic [31:0] val, input logic cr, input logic rdy);
    logic [NP-1:0][FS-1:0] d;
    logic [NP-1:0]         m;
    d = '0; m = '0;
    d[p] = val; m[p] = 1'b1;
    step(m, cr ? m : '0, d, rdy);
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, '0, rdy);
  endtask

  task automatic send_pkt(input int p, input logic [15:0] tg, input logic [31:0] sz,
                          input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                          input int stall_at, input int stall_n, input logic rdy);
    logic [31:0] v;
    for (int f = 0; f < 2 + int'(sz); f++) begin
      if (f == stall_at) repeat (stall_n) flit(p, 32'hDEAD_0000, 1'b0, rdy);
      case (f)
        0:       v = {16'hBEEF, tg};
        1:       v = sz;
        2:       v = s0;
        3:       v = s1;
        4:       v = s2;
        default: v = $urandom;
      endcase
      flit(p, v, 1'b1, rdy);
    end
  endtask

  task automatic do_reset();
    rx_i = '0; credit_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", rec_valid_o, 1'b0);
    chk("rst_level", fifo_level_o, 3'd0);
    chk("rst_drop", drop_cnt_o, 16'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    logic [NP-1:0][FS-1:0] d;
    logic [NP-1:0]         rxm;
    logic [NP-1:0]         crm;
    logic                  rdy;

    rst_ni = 1'b1; rx_i = '0; credit_i = '0; data_i = '0; rec_ready_i = 1'b0;
    tick = 64'd0; tick_cntr_i = '0; cyc = 0;
    model_reset();
    do_reset();

    // Basic packet on port 0, header at tick 100.
    tick = 64'd100;
    send_pkt(0, 16'h0105, 32'd3, 32'h40, 32'h7, 32'h2, -1, 0, 1'b0);
    chk("p31_valid_t1p1", rec_valid_o, 1'b0);
    idle(1'b0);
    chk("p31_valid_t1p2", rec_valid_o, 1'b1);
    chk("p31_port", rec_port_o, 3'd0);
    chk("p31_time", rec_time_o, 64'd100);
    chk("p31_target", rec_target_o, 16'h0105);
    chk("p31_size", rec_size_o, 32'd3);
    chk("p31_service", rec_service_o, 32'h40);
    chk("p31_task", rec_task_o, 16'h7);
    chk("p31_cons", rec_cons_o, 16'h2);
    chk("p31_bw", rec_bw_o, 32'd5);
    idle(1'b0);
    chk("p31_hold_bw", rec_bw_o, 32'd5);
    idle(1'b1);

    // Zero-size packet on port 1.
    send_pkt(1, 16'h0222, 32'd0, 0, 0, 0, -1, 0, 1'b0);
    idle(1'b0);
    chk("p32_port", rec_port_o, 3'd1);
    chk("p32_size", rec_size_o, 32'd0);
    chk("p32_service", rec_service_o, 32'd0);
    chk("p32_task", rec_task_o, 16'd0);
    chk("p32_cons", rec_cons_o, 16'd0);
    chk("p32_bw", rec_bw_o, 32'd2);
    idle(1'b1);

    // Same packet with a 3-cycle credit stall before payload flit 1.
    tick = 64'd200;
    send_pkt(0, 16'h0105, 32'd3, 32'h40, 32'h7, 32'h2, 3, 3, 1'b0);
    idle(1'b0);
    chk("p33_bw", rec_bw_o, 32'd8);
    chk("p33_time", rec_time_o, 64'd200);
    chk("p33_task", rec_task_o, 16'h7);
    chk("p33_cons", rec_cons_o, 16'h2);
    idle(1'b1);

    // Ports 0, 2, 4 complete together: emitted in port order, one per cycle.
    do_reset();
    d = '0; d[0] = 32'h0000_0A00; d[2] = 32'h0000_0A02; d[4] = 32'h0000_0A04;
    step(5'b10101, 5'b10101, d, 1'b1);
    step(5'b10101, 5'b10101, '0, 1'b1);
    chk("p34_valid_t1p1", rec_valid_o, 1'b0);
    idle(1'b1);
    chk("p34_first", rec_port_o, 3'd0);
    idle(1'b1);
    chk("p34_second", rec_port_o, 3'd2);
    idle(1'b1);
    chk("p34_third", rec_port_o, 3'd4);
    chk("p34_third_target", rec_target_o, 16'h0A04);
    idle(1'b1);
    chk("p34_empty", rec_valid_o, 1'b0);

    // Back-to-back zero-size packets with ready low: FIFO fills, slot holds one, sixth drops.
    do_reset();
    for (int n = 0; n < 6; n++) begin
      hdr_tick[n] = tick;
      send_pkt(0, 16'(16'h0500 + n), 32'd0, 0, 0, 0, -1, 0, 1'b0);
    end
    chk("p35_level", fifo_level_o, 3'd4);
    chk("p35_drop", drop_cnt_o, 16'd1);
    for (int n = 0; n < 5; n++) begin
      chk("p35_drain_time", rec_time_o, hdr_tick[n]);
      idle(1'b1);
    end
    chk("p35_drained", rec_valid_o, 1'b0);

    // Reset in the middle of a payload abandons that packet.
    do_reset();
    flit(0, 32'h0000_0333, 1'b1, 1'b1);
    flit(0, 32'd4, 1'b1, 1'b1);
    flit(0, 32'h11, 1'b1, 1'b1);
    do_reset();
    repeat (4) idle(1'b1);
    chk("p36_no_rec", rec_valid_o, 1'b0);
    send_pkt(0, 16'h0444, 32'd1, 32'h99, 0, 0, -1, 0, 1'b0);
    idle(1'b0);
    chk("p36_target", rec_target_o, 16'h0444);
    chk("p36_size", rec_size_o, 32'd1);
    chk("p36_service", rec_service_o, 32'h99);
    chk("p36_task", rec_task_o, 16'd0);
    chk("p36_cons", rec_cons_o, 16'd0);
    chk("p36_bw", rec_bw_o, 32'd3);
    idle(1'b1);

    // Random traffic on all ports with random credit and consumer back-pressure.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++) begin
        d[p]   = (ph[p] == 1) ? 32'($urandom_range(0, 5)) : $urandom;
        crm[p] = ($urandom_range(0, 3) != 0);
      end
      rxm = NP'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(rxm, crm, d, rdy);
    end
    repeat (20) idle(1'b1);
    chk("final_empty", rec_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
